// File: rtl/multi_led_blinker.sv
// Multi-channel LED blinker: shared ms-style timebase feeding N_CH independent
// OFF/ON/BLINK/PULSE channels, each with its own half-period counter.
module mlb_chan #(
  parameter int HP_W   = 16,
  parameter int DEF_HP = 500
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            sync,
  input  logic            we,
  input  logic [3:0]      step,
  input  logic [1:0]      wr_mode,
  input  logic [HP_W-1:0] wr_hp,
  output logic            led
);
  localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2;

  logic [1:0]      mode_q, mode_d;
  logic [HP_W-1:0] hp_q, hp_d, cnt_q, cnt_d, hp_eff;
  logic            phase_q, phase_d, pflag_q, pflag_d, led_q, led_d;
  logic [HP_W:0]   sum;

  always_comb begin
    mode_d  = mode_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    pflag_d = pflag_q;
    hp_eff  = (hp_q == '0) ? HP_W'(1) : hp_q;
    // Extra sum bit so a large step can never alias back below hp_eff.
    sum     = {1'b0, cnt_q} + (HP_W+1)'(step);
    if (tick && !sync) begin
      pflag_d = 1'b0;
      if (mode_q[1]) begin
        if (sum >= {1'b0, hp_eff}) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
          pflag_d = ~phase_q;
        end else begin
          cnt_d = sum[HP_W-1:0];
        end
      end
    end
    if (sync) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      pflag_d = 1'b0;
    end
    if (we) begin
      mode_d  = wr_mode;
      hp_d    = wr_hp;
      cnt_d   = '0;
      phase_d = 1'b0;
      pflag_d = 1'b0;
    end
    case (mode_q)
      M_OFF:   led_d = 1'b0;
      M_ON:    led_d = 1'b1;
      M_BLINK: led_d = phase_q;
      default: led_d = pflag_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= M_OFF;
      hp_q    <= HP_W'(DEF_HP);
      cnt_q   <= '0;
      phase_q <= 1'b0;
      pflag_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pflag_q <= pflag_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;
endmodule

module multi_led_blinker #(
  parameter int N_CH     = 10,
  parameter int TICK_DIV = 50000,
  parameter int HP_W     = 16,
  parameter int DEF_HP   = 500,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            CLOCK_50,
  input  logic            RST,
  input  logic [1:0]      speed,
  input  logic            sync,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [1:0]      cfg_mode,
  input  logic [HP_W-1:0] cfg_hp,
  output logic [N_CH-1:0] led,
  output logic            tick
);
  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [3:0]    step;

  always_comb begin
    step    = 4'b0001 << speed;
    tick_d  = (presc_q == PW'(TICK_DIV-1)) && !sync;
    presc_d = (presc_q == PW'(TICK_DIV-1)) ? '0 : presc_q + 1'b1;
    if (sync) presc_d = '0;
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

  // Channels index-match cfg_ch, so out-of-range writes hit no instance.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    mlb_chan #(.HP_W(HP_W), .DEF_HP(DEF_HP)) u_ch (
      .clk     (CLOCK_50),
      .rst     (RST),
      .tick    (tick_q),
      .sync    (sync),
      .we      (cfg_we && (cfg_ch == CH_W'(i))),
      .step    (step),
      .wr_mode (cfg_mode),
      .wr_hp   (cfg_hp),
      .led     (led[i])
    );
  end
endmodule

// File: tb/tb_multi_led_blinker.sv
// Directed bench: cycle table for the basic BLINK/PULSE/ON timeline, then
// hand sequences for speed, sync, write-on-tick, out-of-range and async reset.
module tb_multi_led_blinker;
  localparam logic [1:0] OFF = 2'd0, ON = 2'd1, BLINK = 2'd2, PULSE = 2'd3;

  logic       clk = 1'b0, rst = 1'b1, sync = 1'b0, we = 1'b0;
  logic [1:0] speed = 2'd0, ch = 2'd0, mode = 2'd0;
  logic [7:0] hp = 8'd0;
  logic [3:0] led4;
  logic [2:0] led3;
  logic       tick4, tick3;
  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  multi_led_blinker #(.N_CH(4), .TICK_DIV(4), .HP_W(8), .DEF_HP(100)) u4 (
    .CLOCK_50(clk), .RST(rst), .speed(speed), .sync(sync), .cfg_we(we),
    .cfg_ch(ch), .cfg_mode(mode), .cfg_hp(hp), .led(led4), .tick(tick4));

  // Three-channel copy sharing the inputs: cfg_ch=3 is out of range here.
  multi_led_blinker #(.N_CH(3), .TICK_DIV(4), .HP_W(8), .DEF_HP(100)) u3 (
    .CLOCK_50(clk), .RST(rst), .speed(speed), .sync(sync), .cfg_we(we),
    .cfg_ch(ch), .cfg_mode(mode), .cfg_hp(hp), .led(led3), .tick(tick3));

  typedef struct {
    logic       we;
    logic [1:0] ch, mode;
    logic [7:0] hp;
    int         adv;
    logic [3:0] exp_led;
    logic       exp_tick;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [1:0] c, input logic [1:0] m, input logic [7:0] h);
    we = 1'b1; ch = c; mode = m; hp = h;
    cyc(1);
    we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; sync = 1'b0; speed = 2'd0;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[13];
    // Edge E0 is the first edge after reset release; comments give the edge
    // each row ends on. Ticks are visible after E3, E7, E11, ...
    tbl[0]  = '{1'b1, 2'd0, BLINK, 8'd3, 1, 4'b0000, 1'b0}; // E0
    tbl[1]  = '{1'b1, 2'd2, ON,    8'd0, 1, 4'b0000, 1'b0}; // E1
    tbl[2]  = '{1'b1, 2'd1, PULSE, 8'd2, 1, 4'b0100, 1'b0}; // E2
    tbl[3]  = '{1'b0, 2'd0, OFF,   8'd0, 1, 4'b0100, 1'b1}; // E3
    tbl[4]  = '{1'b0, 2'd0, OFF,   8'd0, 5, 4'b0100, 1'b0}; // E8
    tbl[5]  = '{1'b0, 2'd0, OFF,   8'd0, 1, 4'b0110, 1'b0}; // E9  pulse on
    tbl[6]  = '{1'b0, 2'd0, OFF,   8'd0, 3, 4'b0110, 1'b0}; // E12
    tbl[7]  = '{1'b0, 2'd0, OFF,   8'd0, 1, 4'b0101, 1'b0}; // E13 blink rise
    tbl[8]  = '{1'b0, 2'd0, OFF,   8'd0, 2, 4'b0101, 1'b1}; // E15
    tbl[9]  = '{1'b0, 2'd0, OFF,   8'd0, 9, 4'b0101, 1'b0}; // E24
    tbl[10] = '{1'b0, 2'd0, OFF,   8'd0, 1, 4'b0110, 1'b0}; // E25 blink fall
    tbl[11] = '{1'b0, 2'd0, OFF,   8'd0, 3, 4'b0110, 1'b0}; // E28
    tbl[12] = '{1'b0, 2'd0, OFF,   8'd0, 1, 4'b0100, 1'b0}; // E29

    @(negedge clk);
    chk("reset_led", 32'(led4), 32'h0);
    chk("reset_tick", 32'(tick4), 32'h0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      we = tbl[i].we; ch = tbl[i].ch; mode = tbl[i].mode; hp = tbl[i].hp;
      cyc(1);
      we = 1'b0;
      cyc(tbl[i].adv - 1);
      chk($sformatf("tbl%0d_led", i), 32'(led4), 32'(tbl[i].exp_led));
      chk($sformatf("tbl%0d_tick", i), 32'(tick4), 32'(tbl[i].exp_tick));
    end

    // Step >= hp_eff and hp=0 both wrap on every tick.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      speed = (k == 0) ? 2'd3 : 2'd0;
      wr(2'd0, BLINK, (k == 0) ? 8'd3 : 8'd0);
      cyc(5); chk($sformatf("fast%0d_e5", k), 32'(led4[0]), 32'h1);
      cyc(3); chk($sformatf("fast%0d_e8", k), 32'(led4[0]), 32'h1);
      cyc(1); chk($sformatf("fast%0d_e9", k), 32'(led4[0]), 32'h0);
      cyc(4); chk($sformatf("fast%0d_e13", k), 32'(led4[0]), 32'h1);
    end

    // sync mid-count realigns prescaler and channels.
    do_reset();
    wr(2'd0, BLINK, 8'd3);
    wr(2'd1, BLINK, 8'd2);
    cyc(12); chk("sync_pre", 32'(led4), 32'h3);
    sync = 1'b1; cyc(1); sync = 1'b0;
    cyc(1); chk("sync_led_clr", 32'(led4), 32'h0);
    cyc(2); chk("sync_tick_e17", 32'(tick4), 32'h0);
    cyc(1); chk("sync_tick_e18", 32'(tick4), 32'h1);
    cyc(6); chk("sync_e24", 32'(led4), 32'h2);
    cyc(4); chk("sync_e28", 32'(led4), 32'h3);

    // Write on a tick cycle restarts ch0; cfg_ch=3 is a no-op on u3.
    do_reset();
    wr(2'd0, BLINK, 8'd3);
    wr(2'd1, BLINK, 8'd3);
    cyc(6); chk("wot_tick", 32'(tick4), 32'h1);
    wr(2'd0, BLINK, 8'd3);
    wr(2'd3, ON, 8'd0);
    cyc(4); chk("wot_e13_u4", 32'(led4), 32'ha);
    chk("wot_e13_u3", 32'(led3), 32'h2);
    cyc(7); chk("wot_e20_u4", 32'(led4), 32'ha);
    chk("wot_e20_u3", 32'(led3), 32'h2);
    cyc(1); chk("wot_e21_u4", 32'(led4), 32'hb);
    chk("wot_e21_u3", 32'(led3), 32'h3);

    // Asynchronous reset between edges.
    do_reset();
    wr(2'd2, ON, 8'd0);
    cyc(2); chk("arst_pre", 32'(led4), 32'h4);
    #2 rst = 1'b1;
    #1 chk("arst_led", 32'(led4), 32'h0);
    chk("arst_tick", 32'(tick4), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(3); chk("arst_tick_e2", 32'(tick4), 32'h0);
    cyc(1); chk("arst_tick_e3", 32'(tick4), 32'h1);
    chk("arst_led_post", 32'(led4), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
